// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, requester ids and the writeback queue entry type
package regfile_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REQ = 3;
  localparam int FIFO_DEPTH = 2;
  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_LOAD = 2'd1;
  localparam logic [1:0] REQ_MAC = 2'd2;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: per-requester writeback queue with a one-hot mask of queued destinations
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  wb_entry_t   push_entry_i,
  output logic        full_o,
  output logic        empty_o,
  output wb_entry_t   head_o,
  output logic [31:0] mask_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  wb_entry_t mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q, wp_d, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign head_o = mem_q[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  // pointer and occupancy next state; pointers wrap at DEPTH even when it is not a power of two
  always_comb begin
    wp_d = do_push ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = do_pop ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // storage is left unreset; only entries inside the occupancy window are ever observed
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wp_q] <= push_entry_i;
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  // mark the destination of every occupied slot, walking from the head
  always_comb begin
    int idx;
    mask_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = (int'(rp_q) + k) % DEPTH;
      if (k < int'(cnt_q)) mask_o[mem_q[idx].rd] = 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: queues writebacks per requester and drains them round-robin into one register-file write port
module regfile_wb_arbiter #(
  parameter int NUM_REQ = regfile_pkg::NUM_REQ,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = regfile_pkg::FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          stall,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_rd,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [1:0]                    grant_id,
  output logic [31:0]                   pending_mask
);
  import regfile_pkg::*;
  wb_entry_t in_entry [NUM_REQ];
  wb_entry_t head [NUM_REQ];
  logic [31:0] fmask [NUM_REQ];
  logic [NUM_REQ-1:0] full, empty, pop;
  logic [1:0] sel, last_grant_q, last_grant_d, grant_q, grant_d;
  logic found, pop_any;
  logic wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_rd_q, wr_rd_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    assign in_entry[i] = {req_rd[i*ADDR_WIDTH +: ADDR_WIDTH], req_data[i*DATA_WIDTH +: DATA_WIDTH]};
    assign req_ready[i] = !full[i];
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (req_valid[i]),
      .pop_i       (pop[i]),
      .push_entry_i(in_entry[i]),
      .full_o      (full[i]),
      .empty_o     (empty[i]),
      .head_o      (head[i]),
      .mask_o      (fmask[i])
    );
  end
  // round-robin pick: first non-empty queue after the last granted one
  always_comb begin
    int idx;
    sel = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel = 2'(idx);
      end
    end
    pop_any = found && !stall;
    pop = pop_any ? NUM_REQ'(1) << sel : '0;
  end
  // output stage next state; rd=0 entries are consumed without a write strobe
  always_comb begin
    last_grant_d = pop_any ? sel : last_grant_q;
    grant_d = pop_any ? sel : grant_q;
    wr_en_d = pop_any && head[sel].rd != '0;
    wr_rd_d = pop_any ? head[sel].rd : wr_rd_q;
    wr_data_d = pop_any ? head[sel].data : wr_data_q;
  end
  // arbitration state and registered write port; reset points last_grant at the top requester so requester 0 wins first
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= 2'(NUM_REQ - 1);
      grant_q <= '0;
      wr_en_q <= 1'b0;
      wr_rd_q <= '0;
      wr_data_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q <= grant_d;
      wr_en_q <= wr_en_d;
      wr_rd_q <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end
  // registers with a queued or in-flight write; x0 is never reported
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) pending_mask = pending_mask | fmask[i];
    if (wr_en_q) pending_mask[wr_rd_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end
  assign wr_en = wr_en_q;
  assign wr_rd = wr_rd_q;
  assign wr_data = wr_data_q;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven cycle checks plus reset-mid-operation sequence
module tb_regfile_wb_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] req_valid = '0;
  logic [2:0] req_ready;
  logic [14:0] req_rd = '0;
  logic [95:0] req_data = '0;
  logic stall = 1'b0;
  logic wr_en;
  logic [4:0] wr_rd;
  logic [31:0] wr_data;
  logic [1:0] grant_id;
  logic [31:0] pending_mask;
  int total = 0;
  int passed = 0;
  logic [31:0] rf [32] = '{default: '0};
  typedef struct {
    logic st;
    logic [2:0] v;
    logic [4:0] r0, r1, r2;
    logic [31:0] d0, d1, d2;
    logic en;
    logic [4:0] wrd;
    logic [31:0] wd;
    logic [1:0] gid;
    logic [2:0] rdy;
    logic [31:0] pm;
  } vec_t;
  vec_t tbl[$];
  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .stall(stall), .wr_en(wr_en),
    .wr_rd(wr_rd), .wr_data(wr_data), .grant_id(grant_id), .pending_mask(pending_mask)
  );
  always #5 clock = ~clock;
  function automatic vec_t mk(input logic [31:0] st, v, r0, r1, r2, d0, d1, d2, en, wrd, wd, gid, rdy, pm);
    vec_t m;
    m.st = st[0]; m.v = v[2:0]; m.r0 = r0[4:0]; m.r1 = r1[4:0]; m.r2 = r2[4:0];
    m.d0 = d0; m.d1 = d1; m.d2 = d2; m.en = en[0]; m.wrd = wrd[4:0]; m.wd = wd;
    m.gid = gid[1:0]; m.rdy = rdy[2:0]; m.pm = pm;
    return m;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic drive(input logic s, input logic [2:0] v, input logic [4:0] r0, r1, r2, input logic [31:0] d0, d1, d2);
    @(negedge clock);
    stall = s;
    req_valid = v;
    req_rd = {r2, r1, r0};
    req_data = {d2, d1, d0};
    @(posedge clock);
    #1;
    if (wr_en) rf[wr_rd] = wr_data;
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst wr_en", 32'(wr_en), 0);
    chk("rst wr_rd", 32'(wr_rd), 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst grant", 32'(grant_id), 0);
    chk("rst pmask", pending_mask, 0);
    chk("rst ready", 32'(req_ready), 7);
    reset = 1'b0;
    // round-robin bursts
    tbl.push_back(mk(0, 7, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 0, 0, 7, 'hE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h11, 0, 7, 'hE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 'h22, 1, 7, 'hC));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 'h33, 2, 7, 'h8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 7, 0));
    tbl.push_back(mk(0, 7, 4, 5, 6, 'h44, 'h55, 'h66, 0, 0, 0, 2, 7, 'h70));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 'h44, 0, 7, 'h70));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'h55, 1, 7, 'h60));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 'h66, 2, 7, 'h40));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 7, 0));
    // single ALU write, two-cycle latency
    tbl.push_back(mk(0, 1, 5, 0, 0, 'hA5, 0, 0, 0, 0, 0, 2, 7, 'h20));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 'hA5, 0, 7, 'h20));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0));
    // rd=0 from MAC is discarded but still granted
    tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, 'hFFFF, 0, 0, 0, 0, 7, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 7, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 7, 0));
    // same destination from ALU and load
    tbl.push_back(mk(0, 3, 7, 7, 0, 1, 2, 0, 0, 0, 0, 2, 7, 'h80));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 7, 'h80));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 2, 1, 7, 'h80));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0));
    // backpressure on load queue under stall
    tbl.push_back(mk(1, 2, 0, 8, 0, 0, 'h81, 0, 0, 0, 0, 1, 7, 'h100));
    tbl.push_back(mk(1, 2, 0, 9, 0, 0, 'h82, 0, 0, 0, 0, 1, 5, 'h300));
    tbl.push_back(mk(1, 2, 0, 10, 0, 0, 'h83, 0, 0, 0, 0, 1, 5, 'h300));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 'h81, 1, 7, 'h300));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 'h82, 1, 7, 'h200));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0));
    // simultaneous push and pop on one queue
    tbl.push_back(mk(0, 1, 11, 0, 0, 'hB1, 0, 0, 0, 0, 0, 1, 7, 'h800));
    tbl.push_back(mk(0, 1, 12, 0, 0, 'hB2, 0, 0, 1, 11, 'hB1, 0, 7, 'h1800));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 'hB2, 0, 7, 'h1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(tbl[i].en));
      chk($sformatf("v%0d grant", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d pmask", i), pending_mask, tbl[i].pm);
      if (tbl[i].en) begin
        chk($sformatf("v%0d wr_rd", i), 32'(wr_rd), 32'(tbl[i].wrd));
        chk($sformatf("v%0d wr_data", i), wr_data, tbl[i].wd);
      end
    end
    chk("rf x7 final", rf[7], 2);
    // four queued entries dropped by a one-cycle reset that overrides valid
    drive(1, 3'b011, 13, 14, 0, 'hD1, 'hE1, 0);
    drive(1, 3'b011, 13, 14, 0, 'hD2, 'hE2, 0);
    chk("mid pmask", pending_mask, 'h6000);
    chk("mid ready", 32'(req_ready), 4);
    reset = 1'b1;
    drive(0, 3'b111, 15, 16, 17, 1, 2, 3);
    chk("mrst wr_en", 32'(wr_en), 0);
    chk("mrst wr_rd", 32'(wr_rd), 0);
    chk("mrst wr_data", wr_data, 0);
    chk("mrst grant", 32'(grant_id), 0);
    chk("mrst pmask", pending_mask, 0);
    chk("mrst ready", 32'(req_ready), 7);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("post%0d wr_en", i), 32'(wr_en), 0);
      chk($sformatf("post%0d pmask", i), pending_mask, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
